// File: rtl/sram_rw_port_arbiter.sv
// sram_rw_port_arbiter: two-requester round-robin arbiter in front of a
// single-port RW SRAM macro (registered address, 1-cycle read latency,
// byte-mask write).
//
// Optional feature macro: SRAM_RW_ARB_INIT_EN
//   defined   : after reset, INIT writes zero to every entry (DEPTH cycles)
//   undefined : INIT issues no SRAM access and lasts one cycle
//
// Ports:
//   i_clock, i_reset_n                  clock, async active-low reset
//   i_reqN_valid/write/addr/wdata/wmask requester N request (N = 0, 1)
//   o_reqN_ready                        requester N granted this cycle
//   o_respN_valid, o_respN_rdata        read response, one cycle after grant
//   o_sram_en/wmode/addr/wdata/wmask    RW0_* drive to the macro
//   i_sram_rdata                        RW0_rdata from the macro
//   o_init_done                         high once in RUN, until next reset
module sram_rw_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_write,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    input  logic [MASK_W-1:0] i_req0_wmask,
    output logic              o_resp0_valid,
    output logic [DATA_W-1:0] o_resp0_rdata,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_write,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    input  logic [MASK_W-1:0] i_req1_wmask,
    output logic              o_resp1_valid,
    output logic [DATA_W-1:0] o_resp1_rdata,
    output logic              o_sram_en,
    output logic              o_sram_wmode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic [MASK_W-1:0] o_sram_wmask,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t r_state, w_state_nxt;
    logic   r_rr_ptr, w_rr_nxt;
    logic   r_resp0_valid, r_resp1_valid;
    logic   w_run, w_win, w_fire0, w_fire1, w_fire;

    assign w_run   = (r_state == RUN);
    // Winner index: a lone requester wins; under contention rr_ptr decides.
    assign w_win   = (i_req0_valid && i_req1_valid) ? r_rr_ptr : i_req1_valid;
    assign w_fire0 = w_run && i_req0_valid && !w_win;
    assign w_fire1 = w_run && i_req1_valid && w_win;
    assign w_fire  = w_fire0 || w_fire1;

    assign o_req0_ready  = w_fire0;
    assign o_req1_ready  = w_fire1;
    assign o_resp0_valid = r_resp0_valid;
    assign o_resp1_valid = r_resp1_valid;
    assign o_resp0_rdata = i_sram_rdata;
    assign o_resp1_rdata = i_sram_rdata;
    assign o_init_done   = w_run;

`ifdef SRAM_RW_ARB_INIT_EN
    logic [ADDR_W-1:0] r_init_cnt;
    logic              w_init_last;

    assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_init_cnt <= '0;
        else if (!w_run)
            r_init_cnt <= r_init_cnt + ADDR_W'(1);
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        o_sram_en    = 1'b0;
        o_sram_wmode = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_wmask = '0;
        if (!w_run) begin
`ifdef SRAM_RW_ARB_INIT_EN
            // Gated by reset so the macro sees no enable while reset is held.
            o_sram_en    = i_reset_n;
            o_sram_wmode = 1'b1;
            o_sram_addr  = r_init_cnt;
            o_sram_wmask = '1;
            w_state_nxt  = w_init_last ? RUN : INIT;
`else
            w_state_nxt  = RUN;
`endif
        end else begin
            o_sram_en    = w_fire;
            o_sram_wmode = w_win ? i_req1_write : i_req0_write;
            o_sram_addr  = w_win ? i_req1_addr  : i_req0_addr;
            o_sram_wdata = w_win ? i_req1_wdata : i_req0_wdata;
            o_sram_wmask = w_win ? i_req1_wmask : i_req0_wmask;
            w_rr_nxt     = w_fire ? !w_win : r_rr_ptr;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= INIT;
            r_rr_ptr      <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_resp0_valid <= w_fire0 && !i_req0_write;
            r_resp1_valid <= w_fire1 && !i_req1_write;
        end
    end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// tb_sram_rw_port_arbiter: scoreboard bench for sram_rw_port_arbiter with a
// behavioural SRAM macro model attached to the RW0 pins.
module tb_sram_rw_port_arbiter;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
    logic [9:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [3:0]  m0 = '0, m1 = '0;
    logic        rdy0, rdy1, rv0, rv1, en, wmode, done;
    logic [31:0] rd0, rd1, swdata, srdata;
    logic [9:0]  saddr;
    logic [3:0]  swmask;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        m_ptr = 1'b0, m_run = 1'b0, pend0 = 1'b0, pend1 = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_rw_port_arbiter dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_write(w0),
        .i_req0_addr(a0), .i_req0_wdata(d0), .i_req0_wmask(m0),
        .o_resp0_valid(rv0), .o_resp0_rdata(rd0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_write(w1),
        .i_req1_addr(a1), .i_req1_wdata(d1), .i_req1_wmask(m1),
        .o_resp1_valid(rv1), .o_resp1_rdata(rd1),
        .o_sram_en(en), .o_sram_wmode(wmode), .o_sram_addr(saddr),
        .o_sram_wdata(swdata), .o_sram_wmask(swmask), .i_sram_rdata(srdata),
        .o_init_done(done)
    );

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (m[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    always @(posedge clk) begin
        if (en) begin
            if (wmode) mem[saddr] <= merge(mem[saddr], swdata, swmask);
            else srdata <= mem[saddr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic e0, e1;
        @(negedge clk);
        e0 = m_run && v0 && (!v1 || !m_ptr);
        e1 = m_run && v1 && !e0;
        chk("rdy0", rdy0, e0);
        chk("rdy1", rdy1, e1);
        chk("en", en, e0 || e1);
        chk("done", done, m_run);
        if (e0 || e1) begin
            chk("wmode", wmode, e1 ? w1 : w0);
            chk("addr", saddr, e1 ? a1 : a0);
            if (e1 ? w1 : w0) begin
                chk("wdata", swdata, e1 ? d1 : d0);
                chk("wmask", swmask, e1 ? m1 : m0);
            end
        end
        chk("rv0", rv0, pend0);
        chk("rv1", rv1, pend1);
        if (pend0 && q0.size() > 0) chk("rd0", rd0, q0.pop_front());
        if (pend1 && q1.size() > 0) chk("rd1", rd1, q1.pop_front());
        pend0 = e0 && !w0;
        pend1 = e1 && !w1;
        if (e0) begin
            if (w0) ref_mem[a0] = merge(ref_mem[a0], d0, m0);
            else q0.push_back(ref_mem[a0]);
        end
        if (e1) begin
            if (w1) ref_mem[a1] = merge(ref_mem[a1], d1, m1);
            else q1.push_back(ref_mem[a1]);
        end
        if (e0 || e1) m_ptr = e0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic rw, input int port,
                         input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        if (port == 0) begin v0 = rv; w0 = rw; a0 = a; d0 = d; m0 = m; end
        else begin v1 = rv; w1 = rw; a1 = a; d1 = d; m1 = m; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        m_ptr = 1'b0; m_run = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_rdy1", rdy1, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rv0", rv0, 1'b0);
        chk("rst_rv1", rv1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = 1'b1; w0 = 1'b0; v1 = 1'b1; w1 = 1'b1;
`ifdef SRAM_RW_ARB_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sw_en", en, 1'b1);
            chk("sw_wmode", wmode, 1'b1);
            chk("sw_addr", saddr, i);
            chk("sw_wdata", swdata, 32'h0);
            chk("sw_wmask", swmask, 4'hF);
            chk("sw_rdy", {rdy1, rdy0}, 2'b00);
            chk("sw_done", done, 1'b0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        @(negedge clk);
        chk("ini_en", en, 1'b0);
        chk("ini_rdy", {rdy1, rdy0}, 2'b00);
        chk("ini_done", done, 1'b0);
        @(posedge clk);
        #1;
`endif
        v0 = 1'b0; v1 = 1'b0;
        m_run = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        do_reset();
        drive(1, 1, 0, 10'd5, 32'hA5A5_0005, 4'hF); step();
        drive(1, 1, 0, 10'd3, 32'h1122_3344, 4'hF); step();
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0);
        drive(1, 1, 1, 10'd9, 32'h0000_0009, 4'hF); step();
        drive(1, 0, 0, 10'd5, 32'h0, 4'h0);
        drive(1, 0, 1, 10'd9, 32'h0, 4'h0);
        repeat (4) step();
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0);
        drive(0, 0, 1, 10'd0, 32'h0, 4'h0);
        step();
        drive(1, 1, 0, 10'd3, 32'hDEAD_BEEF, 4'b0101); step();
        drive(1, 0, 0, 10'd3, 32'h0, 4'h0); step();
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, (i % 2) ? 10'd9 : 10'd5, 32'h0, 4'h0);
            step();
        end
        drive(1, 0, 0, 10'd3, 32'h0, 4'h0);
        drive(1, 0, 1, 10'd9, 32'h0, 4'h0);
        step();
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0);
        drive(0, 0, 1, 10'd0, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                  10'($urandom_range(0, 15)), $urandom, 4'($urandom));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
                  10'($urandom_range(0, 15)), $urandom, 4'($urandom));
            step();
        end
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0);
        drive(0, 0, 1, 10'd0, 32'h0, 4'h0);
        repeat (2) step();
        drive(1, 0, 0, 10'd5, 32'h0, 4'h0); step();
        v0 = 1'b0;
        chk("mid_rv0_pre", rv0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rv0", rv0, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_en", en, 1'b0);
        do_reset();
        drive(1, 0, 0, 10'd5, 32'h0, 4'h0); step();
        drive(1, 0, 1, 10'd9, 32'h0, 4'h0); step();
        drive(0, 0, 0, 10'd0, 32'h0, 4'h0);
        drive(0, 0, 1, 10'd0, 32'h0, 4'h0);
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_rw_port_arbiter.md
Name: sram_rw_port_arbiter

Overview:
- Shares one single-port read/write SRAM macro between two requesters. The macro has a registered address, one-cycle read latency and a byte-mask write (data/tag array style, RW0_* pins).
- Round-robin grant, one access per cycle; read data is returned to the requester that issued the read.
- Optional post-reset sweep zeroes every SRAM entry before requests are accepted.
- Sits between the cache/scratchpad pipelines and the `*_ext` SRAM macro.

Parameters:
- ADDR_W, 10, SRAM address width.
- DEPTH, 1024, number of SRAM entries; must be ≤ 2^ADDR_W.
- DATA_W, 32, data width.
- MASK_W, 4, write-mask width; each bit covers DATA_W/MASK_W bits.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 request.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  address.
- req0_wdata  in  DATA_W  write data.
- req0_wmask  in  MASK_W  write byte mask.
- resp0_valid  out  1  read data valid for requester 0.
- resp0_rdata  out  DATA_W  read data.
- req1_* / resp1_*  same set, same widths, requester 1.
- sram_en  out  1  to RW0_en.
- sram_wmode  out  1  to RW0_wmode.
- sram_addr  out  ADDR_W  to RW0_addr.
- sram_wdata  out  DATA_W  to RW0_wdata.
- sram_wmask  out  MASK_W  to RW0_wmask.
- sram_rdata  in  DATA_W  from RW0_rdata.
- init_done  out  1  high once INIT has finished; stays high until reset.

Behaviour:
- Clocking and reset: one clock, `clock`; reset is asynchronous and active-low on `reset_n`. Every flop clears on reset assertion without waiting for a clock edge.
- Reset values:
  - state = INIT, rr_ptr = 0, init_cnt = 0.
  - init_done = 0, resp0_valid = resp1_valid = 0.
  - All readies are 0 and sram_en = 0 while reset is held.
- States: INIT → RUN. RUN is never left except by reset.
- INIT (sweep build):
  - Each cycle drives sram_en = 1, sram_wmode = 1, sram_addr = init_cnt, sram_wdata = 0, sram_wmask = all ones; then init_cnt increments.
  - On the cycle with init_cnt == DEPTH-1: that write is issued, state → RUN and init_done → 1 at the next edge.
  - INIT lasts exactly DEPTH cycles. Readies are 0 throughout.
- RUN grant (combinational from the registered rr_ptr):
  - Only one valid: that requester wins.
  - Both valid: the requester selected by rr_ptr wins.
  - reqN_ready = (state == RUN) && winner == N.
  - A fire is valid && ready. On a fire, rr_ptr ← the other requester index. No fire: rr_ptr holds.
- SRAM drive in RUN:
  - sram_en = any fire; sram_wmode/addr/wdata/wmask are the winner's fields.
  - No fire: sram_en = 0 and the data/addr/mask outputs are don't-care.
  - Requests are not registered; the macro registers them internally.
- Read response:
  - A read fire by requester N at cycle t sets respN_valid = 1 in cycle t+1 only, for exactly one cycle.
  - respN_rdata = sram_rdata (combinational pass-through) for both requesters; it is meaningful only while respN_valid.
  - No backpressure on responses; the requester must capture in t+1.
- Writes produce no response.
- Back-to-back: reads or writes may fire every cycle, alternating requesters under contention. A read at t+1 does not disturb the response for the read at t.
- Same-address write at t followed by read at t+1 returns the new data (macro write-then-read ordering).
- Reset mid-operation:
  - A pending response is dropped (respN_valid = 0 asynchronously).
  - A sweep in progress restarts from address 0 after reset release.
- Requester inputs are ignored while not in RUN; no queueing.

Optional Feature:
- Macro: SRAM_RW_ARB_INIT_EN.
- Defined: INIT performs the DEPTH-cycle zero sweep described above.
- Undefined: no init counter is built, and INIT issues no SRAM access (sram_en = 0). It transitions to RUN on the first clock edge after reset release, so init_done = 1 and requests are accepted from the second cycle.

Test Plan:
- Sweep build, reset release: sram_en = 1 with wmode = 1, wdata = 0, wmask = 4'hF for addresses 0..1023 in 1024 consecutive cycles; init_done rises next cycle; no ready before that.
- Both requesters hold read valid at addresses 5 and 9 (pre-written 0xA5A5_0005 / 0x0000_0009): grants alternate 0,1,0,1 starting with requester 0; resp0 = 0xA5A5_0005, resp1 = 0x0000_0009, each one cycle after its grant.
- Req0 writes 0xDEADBEEF with mask 4'b0101 to address 3 (old 0x11223344), then reads address 3 next cycle: resp0_rdata = 0x11AD33EF.
- Only req1 valid for 4 cycles: req1 granted every cycle, req0_ready stays 0, rr_ptr ends at 0.
- Issue a req0 read, assert reset_n = 0 in the following cycle: resp0_valid drops immediately and init_done = 0; in the sweep build the sweep restarts at address 0.
- Non-sweep build: reset release at t: no SRAM write; init_done = 1 and a read accepted at t+1 returns data at t+2.
